led_pattern_scheduler: RTL and testbench
========================================

Name: led_pattern_scheduler

Overview:
Sequences a WIDTH-bit LED bank through four shift patterns.
- Patterns: fill/drain, chase, bounce, blink.
- Steps are paced by an internal clock prescaler.
- Pattern changes, whether requested manually or by auto-rotation, take effect only at a pattern-cycle boundary, so the bank never glitches mid-pattern.
- Sits between the board clock/reset and the LED pins. Replaces free-running single-pattern shifters as the top-level LED controller.

Parameters:
WIDTH, 8, number of LEDs; minimum 2.
DIV, 4, clk cycles per pattern step; minimum 1.
REPEAT, 2, complete pattern cycles per mode before auto-rotation advances; minimum 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  run enable; 0 freezes all state (prescaler included).
auto  input  1  1 = rotate modes automatically; 0 = use mode_sel.
mode_sel  input  2  requested mode when auto=0 (0 FILL, 1 CHASE, 2 BOUNCE, 3 BLINK).
out  output  WIDTH  LED drive, registered.
mode  output  2  currently active mode, registered.
step_tick  output  1  1-cycle pulse, high in the cycle after out updates.
cycle_done  output  1  1-cycle pulse, high in the cycle after a pattern cycle completes.

Behaviour:
- Reset (sync, overrides en):
  - out=0, mode=0 (FILL).
  - Prescaler=0, repeat count=0.
  - step_tick=0, cycle_done=0.
- Prescaler:
  - Counts 0..DIV-1 while en=1.
  - A step occurs on the edge where count==DIV-1; count then wraps to 0.
  - DIV=1: a step every cycle.
  - en=0: count, out, mode and repeat count hold; no pulses.
- Start values: FILL=0, CHASE=1, BOUNCE=1, BLINK=0.
- FILL (mode 0):
  - Fill phase: out<={out[WIDTH-2:0],1}.
  - Once out is all ones, drain phase: out<={out[WIDTH-2:0],0}.
  - Cycle = 2*WIDTH steps; completes on the step returning to 0.
  - Phase is tracked by an internal direction bit.
- CHASE (mode 1):
  - Rotate left by one.
  - Cycle = WIDTH steps; completes on the step returning to 1.
- BOUNCE (mode 2):
  - Single 1 moves toward the MSB; at the MSB it reverses and moves toward the LSB.
  - Cycle = 2*WIDTH-2 steps; completes on the step returning to 1.
- BLINK (mode 3):
  - out toggles between 0 and all ones.
  - Cycle = 2 steps; completes on the step returning to 0.
- Boundary (completing step):
  - next mode = mode_sel if auto=0.
  - If auto=1: repeat count increments. When it reaches REPEAT, next mode = mode+1 (3 wraps to 0) and the count clears; otherwise next mode = current mode.
  - On the same edge: mode<=next mode; out<=start value of next mode; direction bit cleared.
  - cycle_done pulses together with step_tick.
- Mid-cycle changes:
  - mode_sel changes and auto toggles mid-cycle are ignored until the boundary; only the value present at the boundary counts.
  - Switching auto 1->0 clears the repeat count at the next boundary.
- Reset mid-pattern aborts immediately, with no completion pulse.
- The start value of the current mode equals the completion value, so an unchanged mode produces no visible discontinuity.

Optional Feature:
LED_ACTIVE_LOW_EN:
- Defined: out is the bitwise complement of the internal pattern register, for active-low LED boards. Reset drives out all ones. mode and the pulses are unchanged.
- Undefined: out equals the pattern register (active-high).

Test Plan:
1. WIDTH=8, DIV=4; reset, then en=1, auto=0, mode_sel=0 -> out steps every 4 clk: 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00. cycle_done only with the 16th step.
2. In FILL, set mode_sel=1 when out=07 -> FILL completes to 00. The boundary step instead loads out=01 with mode=1. Then 02,04,...,80,01, with cycle_done on the 8th CHASE step.
3. CHASE at out=10; drop en for 10 clk -> out, mode and prescaler hold, no pulses. Raising en resumes with the remaining prescaler count, next out=20.
4. auto=1, REPEAT=2, from reset -> mode 0 for 32 steps, mode 1 for 16, mode 2 for 28, mode 3 for 4, then mode 0. mode changes only on cycle_done steps.
5. BOUNCE at out=20 moving toward the LSB; assert reset for 1 clk while en=1 -> next edge out=00, mode=0, step_tick=0, cycle_done=0. First step after release occurs DIV cycles later with out=01.
6. Compile with LED_ACTIVE_LOW_EN; rerun scenario 1 -> out reads FF after reset, then FF,FE,FC,...,00,01,...,FF. mode and pulses are identical to scenario 1.

Source files
------------

// File: rtl/led_pattern_scheduler.sv
// LED bank sequencer cycling FILL, CHASE, BOUNCE and BLINK patterns with boundary-only mode changes.
// Optional build macro LED_ACTIVE_LOW_EN inverts the LED drive for active-low boards.
module led_pattern_scheduler #(
    parameter int WIDTH  = 8,
    parameter int DIV    = 4,
    parameter int REPEAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             auto,
    input  logic [1:0]       mode_sel,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       mode,
    output logic             step_tick,
    output logic             cycle_done
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        CHASE  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_t;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT + 1) : 1;
    localparam logic [CW-1:0]    DIV_LAST = CW'(DIV - 1);
    localparam logic [RW-1:0]    REP_LAST = RW'(REPEAT - 1);
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Each pattern's start value doubles as its completion value.
    function automatic logic [WIDTH-1:0] startValue(input mode_t m);
        logic [WIDTH-1:0] v;
        v = '0;
        if (m == CHASE || m == BOUNCE) begin
            v = ONE;
        end
        return v;
    endfunction

    logic [CW-1:0]    prescale, prescaleD;
    logic [WIDTH-1:0] pat, patD, shiftPat;
    logic             dir, dirD, shiftDir;
    mode_t            curMode, modeD, nextMode;
    logic [RW-1:0]    rptCnt, rptD, nextRpt;
    logic             tickD, doneD;
    logic             stepNow, wrapNow;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale   <= '0;
            pat        <= '0;
            dir        <= 1'b0;
            curMode    <= FILL;
            rptCnt     <= '0;
            step_tick  <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            prescale   <= prescaleD;
            pat        <= patD;
            dir        <= dirD;
            curMode    <= modeD;
            rptCnt     <= rptD;
            step_tick  <= tickD;
            cycle_done <= doneD;
        end
    end

    // Pattern advance for the current mode; dir marks the drain (FILL) or downward (BOUNCE) half.
    always_comb begin
        shiftPat = pat;
        shiftDir = dir;
        case (curMode)
            FILL: begin
                if (!dir && pat == ONES) begin
                    shiftPat = {pat[WIDTH-2:0], 1'b0};
                    shiftDir = 1'b1;
                end else if (dir) begin
                    shiftPat = {pat[WIDTH-2:0], 1'b0};
                end else begin
                    shiftPat = {pat[WIDTH-2:0], 1'b1};
                end
            end
            CHASE: begin
                shiftPat = {pat[WIDTH-2:0], pat[WIDTH-1]};
            end
            BOUNCE: begin
                if (!dir && pat[WIDTH-1]) begin
                    shiftPat = pat >> 1;
                    shiftDir = 1'b1;
                end else if (dir) begin
                    shiftPat = pat >> 1;
                end else begin
                    shiftPat = pat << 1;
                end
            end
            default: begin
                shiftPat = (pat == '0) ? ONES : '0;
            end
        endcase
    end

    // Boundary decision: manual select, or auto-rotation after REPEAT completed cycles.
    always_comb begin
        stepNow  = en && (prescale == DIV_LAST);
        wrapNow  = (shiftPat == startValue(curMode));
        nextMode = curMode;
        nextRpt  = rptCnt;
        if (!auto) begin
            nextMode = mode_t'(mode_sel);
            nextRpt  = '0;
        end else if (rptCnt == REP_LAST) begin
            nextMode = mode_t'(2'(curMode + 2'd1));
            nextRpt  = '0;
        end else begin
            nextRpt = rptCnt + RW'(1);
        end
    end

    always_comb begin
        prescaleD = prescale;
        patD      = pat;
        dirD      = dir;
        modeD     = curMode;
        rptD      = rptCnt;
        tickD     = 1'b0;
        doneD     = 1'b0;
        if (en) begin
            prescaleD = (prescale == DIV_LAST) ? '0 : prescale + CW'(1);
            if (stepNow) begin
                tickD = 1'b1;
                if (wrapNow) begin
                    modeD = nextMode;
                    rptD  = nextRpt;
                    patD  = startValue(nextMode);
                    dirD  = 1'b0;
                    doneD = 1'b1;
                end else begin
                    patD = shiftPat;
                    dirD = shiftDir;
                end
            end
        end
    end

`ifdef LED_ACTIVE_LOW_EN
    assign out = ~pat;
`else
    assign out = pat;
`endif
    assign mode = curMode;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed self-checking bench for led_pattern_scheduler (WIDTH=8, DIV=4, REPEAT=2).
module tb_led_pattern_scheduler;

    localparam int WIDTH  = 8;
    localparam int DIV    = 4;
    localparam int REPEAT = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             auto;
    logic [1:0]       mode_sel;
    logic [WIDTH-1:0] out;
    logic [1:0]       mode;
    logic             step_tick;
    logic             cycle_done;

    int vectors     = 0;
    int miscompares = 0;
    int gapCycles;

    logic [7:0] fillSeq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [7:0] bounceSeq [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};

    led_pattern_scheduler #(.WIDTH(WIDTH), .DIV(DIV), .REPEAT(REPEAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .auto       (auto),
        .mode_sel   (mode_sel),
        .out        (out),
        .mode       (mode),
        .step_tick  (step_tick),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] expOut(input logic [7:0] p);
`ifdef LED_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    // Mode expected after auto-rotation step k (REPEAT=2: 32 FILL, 16 CHASE, 28 BOUNCE, 4 BLINK).
    function automatic logic [1:0] autoMode(input int k);
        if (k < 32) return 2'd0;
        if (k < 48) return 2'd1;
        if (k < 76) return 2'd2;
        if (k < 80) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic autoBoundary(input int k);
        return (k == 16 || k == 32 || k == 40 || k == 48 ||
                k == 62 || k == 76 || k == 78 || k == 80);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic a, input logic [1:0] s);
        reset    = r;
        en       = e;
        auto     = a;
        mode_sel = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitStep(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!step_tick && cycles < 50);
        checkOutput("stepSeen", 32'(step_tick), 32'd1);
    endtask

    task automatic stepCheck(input string tag, input logic [7:0] pat, input logic [1:0] m,
                             input logic done, input int gap);
        int c;
        waitStep(c);
        checkOutput({tag, ".out"}, 32'(out), 32'(expOut(pat)));
        checkOutput({tag, ".mode"}, 32'(mode), 32'(m));
        checkOutput({tag, ".cycle_done"}, 32'(cycle_done), 32'(done));
        if (gap > 0) begin
            checkOutput({tag, ".gap"}, 32'(c), 32'(gap));
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        tick();
        tick();
        checkOutput("reset.out", 32'(out), 32'(expOut(8'h00)));
        checkOutput("reset.mode", 32'(mode), 32'd0);
        checkOutput("reset.step_tick", 32'(step_tick), 32'd0);
        checkOutput("reset.cycle_done", 32'(cycle_done), 32'd0);

        // FILL cycle: 16 steps, completion only on the return to 00.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 16; i++) begin
            stepCheck("fill", fillSeq[i], 2'd0, (i == 15), DIV);
        end

        // Request CHASE mid-FILL; it lands only at the FILL boundary.
        for (int i = 0; i < 3; i++) begin
            stepCheck("fill2", fillSeq[i], 2'd0, 1'b0, DIV);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd1);
        for (int i = 3; i < 15; i++) begin
            stepCheck("fill2", fillSeq[i], 2'd0, 1'b0, DIV);
        end
        stepCheck("toChase", 8'h01, 2'd1, 1'b1, DIV);
        for (int i = 1; i < 8; i++) begin
            stepCheck("chase", 8'(1 << i), 2'd1, 1'b0, DIV);
        end
        stepCheck("chaseWrap", 8'h01, 2'd1, 1'b1, DIV);

        // Freeze with en=0 two cycles into a step; resume needs the remaining 2 cycles.
        for (int i = 1; i < 5; i++) begin
            stepCheck("chase3", 8'(1 << i), 2'd1, 1'b0, DIV);
        end
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("hold.out", 32'(out), 32'(expOut(8'h10)));
            checkOutput("hold.mode", 32'(mode), 32'd1);
            checkOutput("hold.step_tick", 32'(step_tick), 32'd0);
            checkOutput("hold.cycle_done", 32'(cycle_done), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd1);
        stepCheck("resume", 8'h20, 2'd1, 1'b0, 2);

        // Into BOUNCE, then reset while moving toward the LSB.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd2);
        stepCheck("chase5", 8'h40, 2'd1, 1'b0, DIV);
        stepCheck("chase5", 8'h80, 2'd1, 1'b0, DIV);
        stepCheck("toBounce", 8'h01, 2'd2, 1'b1, DIV);
        for (int i = 0; i < 9; i++) begin
            stepCheck("bounce", bounceSeq[i], 2'd2, 1'b0, DIV);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd2);
        tick();
        checkOutput("midReset.out", 32'(out), 32'(expOut(8'h00)));
        checkOutput("midReset.mode", 32'(mode), 32'd0);
        checkOutput("midReset.step_tick", 32'(step_tick), 32'd0);
        checkOutput("midReset.cycle_done", 32'(cycle_done), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
        stepCheck("afterReset", 8'h01, 2'd0, 1'b0, DIV);

        // Auto-rotation from reset through a full lap of the four modes.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0);
        for (int k = 1; k <= 82; k++) begin
            waitStep(gapCycles);
            checkOutput("auto.mode", 32'(mode), 32'(autoMode(k)));
            checkOutput("auto.cycle_done", 32'(cycle_done), 32'(autoBoundary(k)));
            if (autoMode(k) != autoMode(k - 1)) begin
                checkOutput("auto.startOut", 32'(out),
                            32'(expOut((autoMode(k) == 2'd1 || autoMode(k) == 2'd2) ? 8'h01 : 8'h00)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
